ntt_stream_ctrl: RTL and testbench

NTT_STREAM_CTRL -- requirements
Module: ntt_stream_ctrl

---
 rtl/ntt_stream_ctrl_if.sv | 35 +++
 rtl/ntt_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_ntt_stream_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stream_ctrl_if.sv
// Stream-in / stream-out / processing-unit bundle for the NTT stream controller.
interface ntt_stream_ctrl_if #(
    parameter int unsigned N = 17,
    parameter int unsigned D = 16
);
    localparam int unsigned W = D * N;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_inv;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;

    logic [W-1:0] pu_a;
    logic         pu_inv;
    logic         pu_rst;
    logic [W-1:0] pu_an;
    logic         pu_done;

    // Controller view
    modport master (
        input  in_valid, in_data, in_inv, out_ready, pu_an, pu_done,
        output in_ready, out_valid, out_data, out_last, pu_a, pu_inv, pu_rst
    );

    // Environment view (source, sink and processing unit)
    modport slave (
        output in_valid, in_data, in_inv, out_ready, pu_an, pu_done,
        input  in_ready, out_valid, out_data, out_last, pu_a, pu_inv, pu_rst
    );
endinterface

// File: rtl/ntt_stream_ctrl.sv
// Frame controller: gathers D coefficients, runs the PU with a timeout, streams the result out.
module ntt_stream_ctrl #(
    parameter int unsigned N   = 17,
    parameter int unsigned D   = 16,
    parameter int unsigned TMO = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ntt_stream_ctrl_if.master       ctrl_if,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int unsigned IW = $clog2(D);
    localparam int unsigned CW = $clog2(TMO + 1);
    localparam int unsigned W  = D * N;

    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] UNLOAD = 2'd2;
    localparam logic [1:0] FLUSH  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  buf_q, buf_d;
    logic          inv_q, inv_d;
    logic          err_q, err_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          pu_rst_q, pu_rst_d;
    logic          busy_q, busy_d;

    logic          in_hs_c;
    logic          out_hs_c;

    assign in_hs_c  = ctrl_if.in_valid & in_ready_q & (state_q == LOAD);
    assign out_hs_c = out_valid_q & ctrl_if.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        inv_d   = inv_q;
        err_d   = err_q;

        case (state_q)
            LOAD: begin
                cnt_d = '0;
                if (in_hs_c) begin
                    buf_d[32'(idx_q) * N +: N] = ctrl_if.in_data;
                    if (idx_q == '0) begin
                        inv_d = ctrl_if.in_inv;
                    end
                    if (idx_q == IW'(D - 1)) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            RUN: begin
                if (ctrl_if.pu_done) begin
                    buf_d   = ctrl_if.pu_an;
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UNLOAD, FLUSH: begin
                if (out_hs_c) begin
                    if (idx_q == IW'(D - 1)) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Outputs follow the state being entered so they line up with it
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == UNLOAD) || (state_d == FLUSH);
        out_data_d  = (state_d == UNLOAD) ? buf_d[32'(idx_d) * N +: N] : '0;
        out_last_d  = out_valid_d && (idx_d == IW'(D - 1));
        pu_rst_d    = (state_d != RUN);
        busy_d      = (state_d != LOAD);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            inv_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pu_rst_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            inv_q       <= inv_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pu_rst_q    <= pu_rst_d;
            busy_q      <= busy_d;
        end
    end

    assign ctrl_if.in_ready  = in_ready_q;
    assign ctrl_if.out_valid = out_valid_q;
    assign ctrl_if.out_data  = out_data_q;
    assign ctrl_if.out_last  = out_last_q;
    assign ctrl_if.pu_a      = buf_q;
    assign ctrl_if.pu_inv    = inv_q;
    assign ctrl_if.pu_rst    = pu_rst_q;
    assign busy_o            = busy_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Directed bench for ntt_stream_ctrl with a small PU model (result = operand + 1, five cycles).
module tb_ntt_stream_ctrl;
    localparam int unsigned N   = 17;
    localparam int unsigned D   = 16;
    localparam int unsigned TMO = 64;
    localparam int unsigned W   = D * N;

    logic       clk;
    logic       rst_n;
    logic       busy_o;
    logic       err_o;
    logic       pu_en;
    logic       pu_force;
    logic [7:0] pu_cnt;

    int n_err = 0;
    int n_chk = 0;

    int run_cyc   = 0;
    int inv_cyc   = 0;
    int bad_stall = 0;

    logic [N-1:0] rx_d[$];
    logic         rx_l[$];

    ntt_stream_ctrl_if #(.N(N), .D(D)) bus ();

    ntt_stream_ctrl #(.N(N), .D(D), .TMO(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PU model: done on the fifth cycle with pu_rst low
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pu_cnt <= 8'd0;
        else if (bus.pu_rst) pu_cnt <= 8'd0;
        else                 pu_cnt <= pu_cnt + 8'd1;
    end

    assign bus.pu_done = pu_force | (pu_en & ~bus.pu_rst & (pu_cnt == 8'd4));

    for (genvar g = 0; g < D; g++) begin : g_pu
        assign bus.pu_an[g*N +: N] = bus.pu_a[g*N +: N] + 17'd1;
    end

    // Cycle monitor: RUN length, direction seen by the PU, input stalls outside RUN/UNLOAD
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.pu_rst) begin
                run_cyc = run_cyc + 1;
                if (bus.pu_inv) inv_cyc = inv_cyc + 1;
            end
            if (bus.in_valid && !bus.in_ready && bus.pu_rst && !bus.out_valid)
                bad_stall = bad_stall + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Push one frame base, base+1, ... ; leaves in_valid asserted
    task automatic send(input int base, input logic inv);
        int   k;
        int   guard;
        logic hs;
        k = 0;
        guard = 0;
        while (k < int'(D) && guard < 1000) begin
            bus.in_valid = 1'b1;
            bus.in_data  = N'(base + k);
            bus.in_inv   = (k == 0) ? inv : 1'b0;
            hs = bus.in_ready;
            tick();
            guard++;
            if (hs) k++;
        end
        check("send_count", 64'(k), 64'(D));
    endtask

    // Collect count output handshakes; mode 1 drives out_ready as 1,0,0,1,...
    task automatic recv(input int count, input int mode);
        int           got;
        int           cyc;
        logic         stalled;
        logic [N-1:0] held_d;
        logic         held_l;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (got < count && cyc < 1000) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(held_d));
                check("hold_last", 64'(bus.out_last), 64'(held_l));
            end
            if (bus.out_valid && bus.out_ready) begin
                rx_d.push_back(bus.out_data);
                rx_l.push_back(bus.out_last);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = bus.out_valid;
                held_d  = bus.out_data;
                held_l  = bus.out_last;
            end
            tick();
            cyc++;
        end
        if (mode != 0 || got >= count) bus.out_ready = 1'b0;
        check("recv_count", 64'(got), 64'(count));
    endtask

    task automatic check_frame(input string tag, input int off, input int base, input logic zero);
        logic [N-1:0] exp_d;
        for (int i = 0; i < int'(D); i++) begin
            exp_d = zero ? '0 : N'(base + i);
            check({tag, "_data"}, 64'(rx_d[off + i]), 64'(exp_d));
            check({tag, "_last"}, 64'(rx_l[off + i]), 64'(i == int'(D) - 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int i0;
        int s0;
        int seen;
        logic [W-1:0] pa;

        rst_n         = 1'b1;
        pu_en         = 1'b1;
        pu_force      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values while reset is held
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_pu_rst", 64'(bus.pu_rst), 64'd1);
        check("rst_pu_inv", 64'(bus.pu_inv), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        pa = bus.pu_a;
        check("rst_pu_a", 64'(pa[N-1:0]), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Stray pu_done while loading is ignored
        pu_force = 1'b1;
        tick();
        pu_force = 1'b0;
        check("stray_done_busy", 64'(busy_o), 64'd0);
        check("stray_done_ready", 64'(bus.in_ready), 64'd1);

        // Forward frame 1..16 -> 2..17
        rx_d.delete(); rx_l.delete();
        r0 = run_cyc; i0 = inv_cyc;
        fork
            begin
                send(1, 1'b0);
                bus.in_valid = 1'b0;
                pa = bus.pu_a;
                check("fwd_pu_a_lo", 64'(pa[N-1:0]), 64'd1);
                check("fwd_pu_a_hi", 64'(pa[W-1 -: N]), 64'd16);
                check("fwd_busy_run", 64'(busy_o), 64'd1);
            end
            recv(16, 0);
        join
        check_frame("fwd", 0, 2, 1'b0);
        check("fwd_run_cycles", 64'(run_cyc - r0), 64'd5);
        check("fwd_inv_cycles", 64'(inv_cyc - i0), 64'd0);
        check("fwd_ready_after", 64'(bus.in_ready), 64'd1);

        // Inverse flag on coefficient 0 only
        rx_d.delete(); rx_l.delete();
        r0 = run_cyc; i0 = inv_cyc;
        fork
            begin send(100, 1'b1); bus.in_valid = 1'b0; end
            recv(16, 0);
        join
        check_frame("inv", 0, 101, 1'b0);
        check("inv_run_cycles", 64'(run_cyc - r0), 64'd5);
        check("inv_inv_cycles", 64'(inv_cyc - i0), 64'd5);

        // Backpressure 1,0,0,1
        rx_d.delete(); rx_l.delete();
        fork
            begin send(200, 1'b0); bus.in_valid = 1'b0; end
            recv(16, 1);
        join
        check_frame("bp", 0, 201, 1'b0);
        check("bp_pu_inv", 64'(bus.pu_inv), 64'd0);

        // Timeout: PU never answers
        pu_en = 1'b0;
        rx_d.delete(); rx_l.delete();
        r0 = run_cyc;
        fork
            begin send(300, 1'b0); bus.in_valid = 1'b0; end
            recv(16, 0);
        join
        check_frame("tmo", 0, 0, 1'b1);
        check("tmo_run_cycles", 64'(run_cyc - r0), 64'(TMO));
        check("tmo_err", 64'(err_o), 64'd1);
        check("tmo_ready_after", 64'(bus.in_ready), 64'd1);
        tick();
        check("tmo_err_sticky", 64'(err_o), 64'd1);
        do_reset();
        check("tmo_err_cleared", 64'(err_o), 64'd0);
        pu_en = 1'b1;

        // Reset in UNLOAD after 7 outputs
        rx_d.delete(); rx_l.delete();
        fork
            begin send(400, 1'b0); bus.in_valid = 1'b0; end
            recv(7, 0);
        join
        check("mr_first_data", 64'(rx_d[0]), 64'd401);
        check("mr_valid_before", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mr_valid_async", 64'(bus.out_valid), 64'd0);
        check("mr_last_async", 64'(bus.out_last), 64'd0);
        check("mr_pu_rst_async", 64'(bus.pu_rst), 64'd1);
        pa = bus.pu_a;
        check("mr_buf_cleared", 64'(pa[N-1:0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            if (bus.out_valid) seen++;
            tick();
        end
        bus.out_ready = 1'b0;
        check("mr_no_outputs", 64'(seen), 64'd0);

        // Back-to-back frames with valid/ready held high
        rx_d.delete(); rx_l.delete();
        s0 = bad_stall;
        fork
            begin send(500, 1'b0); send(600, 1'b0); bus.in_valid = 1'b0; end
            recv(32, 0);
        join
        check_frame("b2b0", 0, 501, 1'b0);
        check_frame("b2b1", 16, 601, 1'b0);
        check("b2b_load_stalls", 64'(bad_stall - s0), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
